// File: rtl/iso_pkg.sv
// Shared types and constants for the DP idle-pattern generator.
// Lane-state enum, idle symbol codes and the lane-count decode.
package iso_pkg;

    typedef enum logic [1:0] {
        LANE_OFF     = 2'd0,
        LANE_WAIT_BS = 2'd1,
        LANE_ACTIVE  = 2'd2
    } lane_state_t;

    localparam logic [7:0] SYM_BS    = 8'hBC;
    localparam logic [7:0] SYM_SR    = 8'h1C;
    localparam logic [7:0] VBID_IDLE = 8'h08;
    localparam logic [7:0] SYM_ZERO  = 8'h00;

    // 2'b10 is reserved and falls back to a single lane.
    function automatic logic [2:0] decode_lane_count(input logic [1:0] code);
        case (code)
            2'b01:   return 3'd2;
            2'b11:   return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/iso_idle_lane_fsm.sv
// One lane of the idle generator: OFF / WAIT_BS / ACTIVE state plus the
// registered symbol, control flag and activate outputs for that lane.
module iso_idle_lane_fsm
    import iso_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_ok,
    input  logic       running_q,
    input  logic       period_last,
    input  logic [7:0] next_symbol,
    input  logic       next_flag,
    output logic       run_d,
    output logic       activate,
    output logic [7:0] symbol,
    output logic       flag
);

    lane_state_t state_q, state_d;
    logic        activate_q, activate_d;
    logic [7:0]  symbol_q, symbol_d;
    logic        flag_q, flag_d;

    always_comb begin
        state_d = state_q;
        if (!en_ok) begin
            state_d = LANE_OFF;
        end else begin
            case (state_q)
                // Join a running pattern only at the next period boundary.
                LANE_OFF:     state_d = running_q ? LANE_WAIT_BS : LANE_ACTIVE;
                LANE_WAIT_BS: if (period_last) state_d = LANE_ACTIVE;
                LANE_ACTIVE:  state_d = LANE_ACTIVE;
                default:      state_d = LANE_OFF;
            endcase
        end
        run_d      = (state_d != LANE_OFF);
        activate_d = (state_d == LANE_ACTIVE);
        symbol_d   = activate_d ? next_symbol : SYM_ZERO;
        flag_d     = activate_d & next_flag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LANE_OFF;
            activate_q <= 1'b0;
            symbol_q   <= 8'h00;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            activate_q <= activate_d;
            symbol_q   <= symbol_d;
            flag_q     <= flag_d;
        end
    end

    assign activate = activate_q;
    assign symbol   = symbol_q;
    assign flag     = flag_q;

endmodule

// File: rtl/iso_idle_pattern_gen.sv
// Per-lane DP idle-pattern source: shared symbol-position/BS counters feed
// four lane FSMs so every active lane emits the same BS-aligned sequence.
module iso_idle_pattern_gen
    import iso_pkg::*;
#(
    parameter int IDLE_PERIOD = 8192,
    parameter int SR_INTERVAL = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] td_lane_count,
    input  logic       sched_idle_en_lane0,
    input  logic       sched_idle_en_lane1,
    input  logic       sched_idle_en_lane2,
    input  logic       sched_idle_en_lane3,
    output logic       idle_activate_en_lane0,
    output logic       idle_activate_en_lane1,
    output logic       idle_activate_en_lane2,
    output logic       idle_activate_en_lane3,
    output logic [7:0] idle_symbol_lane0,
    output logic [7:0] idle_symbol_lane1,
    output logic [7:0] idle_symbol_lane2,
    output logic [7:0] idle_symbol_lane3,
    output logic       idle_control_sym_flag_lane0,
    output logic       idle_control_sym_flag_lane1,
    output logic       idle_control_sym_flag_lane2,
    output logic       idle_control_sym_flag_lane3
);

    localparam int CNT_W = $clog2(IDLE_PERIOD);
    localparam int BS_W  = $clog2(SR_INTERVAL);
    localparam logic [CNT_W-1:0] POS_LAST = CNT_W'(IDLE_PERIOD - 1);

    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [BS_W-1:0]  bs_cnt_q, bs_cnt_d;
    logic             running_q, running_d;
    logic [3:0]       en_vec, lane_ok, lane_run_d, act_vec, flag_vec;
    logic [7:0]       sym_vec [4];
    logic [2:0]       lane_cnt;
    logic [7:0]       next_symbol;
    logic             next_flag;
    logic             period_last;

    assign en_vec      = {sched_idle_en_lane3, sched_idle_en_lane2,
                          sched_idle_en_lane1, sched_idle_en_lane0};
    assign lane_cnt    = decode_lane_count(td_lane_count);
    assign period_last = (sym_cnt_q == POS_LAST);
    assign running_d   = |lane_run_d;

    always_comb begin
        sym_cnt_d = sym_cnt_q;
        bs_cnt_d  = bs_cnt_q;
        if (!running_d) begin
            sym_cnt_d = '0;
            bs_cnt_d  = '0;
        end else if (!running_q) begin
            sym_cnt_d = '0;
        end else begin
            sym_cnt_d = sym_cnt_q + 1'b1;
            // bs_cnt advances after each position-0 symbol, so it is 0 on the first.
            if (sym_cnt_q == '0) bs_cnt_d = bs_cnt_q + 1'b1;
        end

        next_symbol = SYM_ZERO;
        next_flag   = 1'b0;
        if (sym_cnt_d == CNT_W'(0)) begin
            next_symbol = (bs_cnt_d == '0) ? SYM_SR : SYM_BS;
            next_flag   = 1'b1;
        end else if (sym_cnt_d == CNT_W'(1)) begin
            next_symbol = VBID_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt_q <= '0;
            bs_cnt_q  <= '0;
            running_q <= 1'b0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            bs_cnt_q  <= bs_cnt_d;
            running_q <= running_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_ok[gi] = (3'(gi) < lane_cnt);
            iso_idle_lane_fsm u_lane (
                .clk         (clk),
                .rst_n       (rst_n),
                .en_ok       (en_vec[gi] & lane_ok[gi]),
                .running_q   (running_q),
                .period_last (period_last),
                .next_symbol (next_symbol),
                .next_flag   (next_flag),
                .run_d       (lane_run_d[gi]),
                .activate    (act_vec[gi]),
                .symbol      (sym_vec[gi]),
                .flag        (flag_vec[gi])
            );
        end
    endgenerate

    assign idle_activate_en_lane0      = act_vec[0];
    assign idle_activate_en_lane1      = act_vec[1];
    assign idle_activate_en_lane2      = act_vec[2];
    assign idle_activate_en_lane3      = act_vec[3];
    assign idle_symbol_lane0           = sym_vec[0];
    assign idle_symbol_lane1           = sym_vec[1];
    assign idle_symbol_lane2           = sym_vec[2];
    assign idle_symbol_lane3           = sym_vec[3];
    assign idle_control_sym_flag_lane0 = flag_vec[0];
    assign idle_control_sym_flag_lane1 = flag_vec[1];
    assign idle_control_sym_flag_lane2 = flag_vec[2];
    assign idle_control_sym_flag_lane3 = flag_vec[3];

endmodule
